// File: rtl/regfile_access_ctrl.sv
// Operand-fetch / writeback sequencer in front of a single-port register file
// (async read, negedge write). Writebacks win over reads; reads fetch rs then rt.
module regfile_access_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 8,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_rs,
  input  logic [ADDR_W-1:0] i_req_rt,
  input  logic [ADDR_W-1:0] i_req_rd,
  input  logic              i_req_rd_we,
  output logic              o_op_valid,
  input  logic              i_op_ready,
  output logic [DATA_W-1:0] o_op_a,
  output logic [DATA_W-1:0] o_op_b,
  output logic [ADDR_W-1:0] o_op_rd,
  output logic              o_op_rd_we,
  input  logic              i_wb_valid,
  output logic              o_wb_ready,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [ADDR_W-1:0] o_rf_addr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic              o_rf_we,
  input  logic [DATA_W-1:0] i_rf_rdata,
  output logic [2:0]        o_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both 1.
  // wb_ready depends only on state; req_ready also yields to a pending writeback.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ_A = 3'd2,
    READ_B = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_op_valid,  w_op_valid_nxt;
  logic [DATA_W-1:0]   r_op_a,      w_op_a_nxt;
  logic [DATA_W-1:0]   r_op_b,      w_op_b_nxt;
  logic [ADDR_W-1:0]   r_op_rd,     w_op_rd_nxt;
  logic                r_op_rd_we,  w_op_rd_we_nxt;
  logic [ADDR_W-1:0]   r_rt,        w_rt_nxt;
  logic [ADDR_W-1:0]   r_rf_addr,   w_rf_addr_nxt;
  logic [DATA_W-1:0]   r_rf_wdata,  w_rf_wdata_nxt;
  logic                r_rf_we,     w_rf_we_nxt;
  logic                w_wb_ready;
  logic                w_req_ready;
  logic                w_wb_discard;

  assign w_wb_ready   = (r_state == IDLE);
  assign w_req_ready  = (r_state == IDLE) && !i_wb_valid;
  assign w_wb_discard = ZERO_PROTECT && (i_wb_addr == '0);

  always_comb begin
    w_state_nxt    = r_state;
    w_op_valid_nxt = r_op_valid;
    w_op_a_nxt     = r_op_a;
    w_op_b_nxt     = r_op_b;
    w_op_rd_nxt    = r_op_rd;
    w_op_rd_we_nxt = r_op_rd_we;
    w_rt_nxt       = r_rt;
    w_rf_addr_nxt  = r_rf_addr;
    w_rf_wdata_nxt = r_rf_wdata;
    w_rf_we_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_wb_valid) begin
          w_rf_addr_nxt  = i_wb_addr;
          w_rf_wdata_nxt = i_wb_data;
          // A discarded r0 write completes its handshake but never pulses rf_we
          if (!w_wb_discard) begin
            w_rf_we_nxt = 1'b1;
            w_state_nxt = WRITE;
          end
        end else if (i_req_valid) begin
          w_op_rd_nxt    = i_req_rd;
          w_op_rd_we_nxt = i_req_rd_we;
          w_rt_nxt       = i_req_rt;
          w_rf_addr_nxt  = i_req_rs;
          w_state_nxt    = READ_A;
        end
      end
      WRITE: begin
        w_state_nxt = IDLE;
      end
      READ_A: begin
        w_op_a_nxt    = i_rf_rdata;
        w_rf_addr_nxt = r_rt;
        w_state_nxt   = READ_B;
      end
      READ_B: begin
        w_op_b_nxt     = i_rf_rdata;
        w_op_valid_nxt = 1'b1;
        w_state_nxt    = HOLD;
      end
      HOLD: begin
        if (i_op_ready) begin
          w_op_valid_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end
      end
      default: begin
        w_op_valid_nxt = 1'b0;
        w_state_nxt    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op_valid <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_rd    <= '0;
      r_op_rd_we <= 1'b0;
      r_rt       <= '0;
      r_rf_addr  <= '0;
      r_rf_wdata <= '0;
      r_rf_we    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op_valid <= w_op_valid_nxt;
      r_op_a     <= w_op_a_nxt;
      r_op_b     <= w_op_b_nxt;
      r_op_rd    <= w_op_rd_nxt;
      r_op_rd_we <= w_op_rd_we_nxt;
      r_rt       <= w_rt_nxt;
      r_rf_addr  <= w_rf_addr_nxt;
      r_rf_wdata <= w_rf_wdata_nxt;
      r_rf_we    <= w_rf_we_nxt;
    end
  end

  assign o_req_ready = w_req_ready;
  assign o_wb_ready  = w_wb_ready;
  assign o_op_valid  = r_op_valid;
  assign o_op_a      = r_op_a;
  assign o_op_b      = r_op_b;
  assign o_op_rd     = r_op_rd;
  assign o_op_rd_we  = r_op_rd_we;
  assign o_rf_addr   = r_rf_addr;
  assign o_rf_wdata  = r_rf_wdata;
  assign o_rf_we     = r_rf_we;
  assign o_state     = r_state;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural 32x8 register file
// (async read, negedge write; fresh contents 0xFF except r0 = 0x00).
module tb_regfile_access_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_READ_B = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_rs = '0, req_rt = '0, req_rd = '0;
  logic       req_rd_we = 1'b0;
  logic       op_valid;
  logic       op_ready = 1'b0;
  logic [7:0] op_a, op_b;
  logic [4:0] op_rd;
  logic       op_rd_we;
  logic       wb_valid = 1'b0;
  logic       wb_ready;
  logic [4:0] wb_addr = '0;
  logic [7:0] wb_data = '0;
  logic [4:0] rf_addr;
  logic [7:0] rf_wdata;
  logic       rf_we;
  logic [7:0] rf_rdata;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  bit we_seen = 0;

  logic [7:0] mem [32];

  regfile_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_rs(req_rs), .i_req_rt(req_rt), .i_req_rd(req_rd), .i_req_rd_we(req_rd_we),
    .o_op_valid(op_valid), .i_op_ready(op_ready),
    .o_op_a(op_a), .o_op_b(op_b), .o_op_rd(op_rd), .o_op_rd_we(op_rd_we),
    .i_wb_valid(wb_valid), .o_wb_ready(wb_ready),
    .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_rf_addr(rf_addr), .o_rf_wdata(rf_wdata), .o_rf_we(rf_we),
    .i_rf_rdata(rf_rdata), .o_state(state)
  );

  // Clock / register file model
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
    mem[0] = 8'h00;
  end

  always @(negedge clk) begin
    if (rf_we) begin
      mem[rf_addr] = rf_wdata;
      we_seen = 1;
    end
  end

  assign rf_rdata = mem[rf_addr];

  // Drivers: every task starts and ends just after a posedge, except
  // start_read which ends on the negedge where op_valid is first seen.
  task automatic do_wb(input logic [4:0] addr, input logic [7:0] data,
                       input logic exp_we, input string name);
    bit acc = 0;
    wb_valid = 1; wb_addr = addr; wb_data = data;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); acc = wb_ready;
      @(posedge clk); #1;
    end
    wb_valid = 0;
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL %s wb_accept: got %0b expected 1", name, acc); end
    checks++;
    if (rf_addr !== addr) begin errors++; $display("FAIL %s rf_addr: got %h expected %h", name, rf_addr, addr); end
    checks++;
    if (rf_wdata !== data) begin errors++; $display("FAIL %s rf_wdata: got %h expected %h", name, rf_wdata, data); end
    checks++;
    if (rf_we !== exp_we) begin errors++; $display("FAIL %s rf_we_after_accept: got %b expected %b", name, rf_we, exp_we); end
    checks++;
    if (state !== (exp_we ? S_WRITE : S_IDLE)) begin
      errors++; $display("FAIL %s state_after_accept: got %0d expected %0d", name, state, exp_we ? S_WRITE : S_IDLE);
    end
    @(posedge clk); #1;
    checks++;
    if (rf_we !== 1'b0 || state !== S_IDLE) begin
      errors++; $display("FAIL %s write_end: got rf_we=%b state=%0d expected rf_we=0 state=0", name, rf_we, state);
    end
  endtask

  task automatic start_read(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic rd_we, input logic [7:0] ea, input logic [7:0] eb,
                            input string name);
    bit acc = 0;
    bit seen = 0;
    int n = 0;
    req_valid = 1; req_rs = rs; req_rt = rt; req_rd = rd; req_rd_we = rd_we;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 0;
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL %s req_accept: got %0b expected 1", name, acc); end
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (op_valid === 1'b1) seen = 1;
      else begin n++; @(posedge clk); #1; end
    end
    checks++;
    if (seen !== 1'b1 || n !== 2) begin
      errors++; $display("FAIL %s latency: got seen=%0b edges=%0d expected seen=1 edges=2", name, seen, n);
    end
    checks++;
    if (op_a !== ea) begin errors++; $display("FAIL %s op_a: got %h expected %h", name, op_a, ea); end
    checks++;
    if (op_b !== eb) begin errors++; $display("FAIL %s op_b: got %h expected %h", name, op_b, eb); end
    checks++;
    if (op_rd !== rd || op_rd_we !== rd_we) begin
      errors++; $display("FAIL %s op_rd: got %h/%b expected %h/%b", name, op_rd, op_rd_we, rd, rd_we);
    end
  endtask

  task automatic release_op(input string name);
    op_ready = 1;
    @(posedge clk); #1;
    op_ready = 0;
    checks++;
    if (state !== S_IDLE || op_valid !== 1'b0) begin
      errors++; $display("FAIL %s release: got state=%0d op_valid=%b expected state=0 op_valid=0", name, state, op_valid);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    #3;
    checks++;
    if (state !== S_IDLE || op_valid !== 0 || op_a !== 0 || op_b !== 0 || op_rd !== 0 || op_rd_we !== 0 ||
        rf_addr !== 0 || rf_wdata !== 0 || rf_we !== 0) begin
      errors++; $display("FAIL reset_outputs: got state=%0d op_valid=%b op_a=%h op_b=%h rf_addr=%h rf_we=%b expected all 0",
                         state, op_valid, op_a, op_b, rf_addr, rf_we);
    end
    #19 rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (wb_ready !== 1'b1 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got wb_ready=%b req_ready=%b expected 1/1", wb_ready, req_ready);
    end
  endtask

  task automatic test_write_read();
    we_seen = 0;
    do_wb(5'd5, 8'hA5, 1'b1, "wr_r5");
    checks++;
    if (we_seen !== 1'b1) begin errors++; $display("FAIL wr_r5 we_seen: got %b expected 1", we_seen); end
    start_read(5'd5, 5'd29, 5'd12, 1'b1, 8'hA5, 8'hFF, "rd_5_29");
    release_op("rd_5_29");
  endtask

  task automatic test_zero_protect();
    we_seen = 0;
    do_wb(5'd0, 8'h33, 1'b0, "wr_r0");
    checks++;
    if (we_seen !== 1'b0) begin errors++; $display("FAIL wr_r0 we_seen: got %b expected 0", we_seen); end
    start_read(5'd0, 5'd0, 5'd3, 1'b0, 8'h00, 8'h00, "rd_0_0");
    release_op("rd_0_0");
  endtask

  task automatic test_priority();
    wb_valid = 1; wb_addr = 5'd7; wb_data = 8'h5C;
    req_valid = 1; req_rs = 5'd7; req_rt = 5'd7; req_rd = 5'd9; req_rd_we = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || wb_ready !== 1'b1) begin
      errors++; $display("FAIL prio_ready: got req_ready=%b wb_ready=%b expected 0/1", req_ready, wb_ready);
    end
    @(posedge clk); #1;
    wb_valid = 0;
    checks++;
    if (state !== S_WRITE || rf_we !== 1'b1) begin
      errors++; $display("FAIL prio_wb_first: got state=%0d rf_we=%b expected 1/1", state, rf_we);
    end
    start_read(5'd7, 5'd7, 5'd9, 1'b1, 8'h5C, 8'h5C, "prio_rd_7_7");
    release_op("prio_rd_7_7");
  endtask

  task automatic test_hold();
    logic [7:0] a0, b0;
    start_read(5'd5, 5'd7, 5'd21, 1'b0, 8'hA5, 8'h5C, "hold_rd");
    a0 = 8'hA5; b0 = 8'h5C;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (op_valid !== 1'b1 || op_a !== a0 || op_b !== b0 || req_ready !== 1'b0 || wb_ready !== 1'b0 || state !== S_HOLD) begin
        errors++; $display("FAIL hold_stable[%0d]: got v=%b a=%h b=%h rr=%b wr=%b st=%0d expected 1/%h/%h/0/0/4",
                           i, op_valid, op_a, op_b, req_ready, wb_ready, state, a0, b0);
      end
    end
    release_op("hold_rd");
    checks++;
    if (wb_ready !== 1'b1) begin errors++; $display("FAIL hold_idle_ready: got %b expected 1", wb_ready); end
  endtask

  task automatic test_reset_mid();
    req_valid = 1; req_rs = 5'd5; req_rt = 5'd29; req_rd = 5'd1; req_rd_we = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (state !== S_READ_B) begin errors++; $display("FAIL rstmid_state: got %0d expected 3", state); end
    #2 rst_n = 0;
    #1;
    checks++;
    if (op_valid !== 0 || rf_we !== 0 || state !== S_IDLE || rf_addr !== 0 || op_a !== 0) begin
      errors++; $display("FAIL rstmid_clear: got v=%b we=%b st=%0d addr=%h a=%h expected all 0",
                         op_valid, rf_we, state, rf_addr, op_a);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    start_read(5'd29, 5'd5, 5'd30, 1'b0, 8'hFF, 8'hA5, "rstmid_rd_29_5");
    release_op("rstmid_rd_29_5");
  endtask

  task automatic test_back_to_back();
    int acc_cyc[4];
    int k = 0;
    int cyc = 0;
    bit acc;
    wb_valid = 1; wb_addr = 5'd1; wb_data = 8'h11;
    while (k < 4 && cyc < 40) begin
      @(negedge clk); acc = wb_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        acc_cyc[k] = cyc;
        k++;
        if (k < 4) begin
          wb_addr = 5'(k + 1);
          wb_data = 8'(8'h11 * (k + 1));
        end else wb_valid = 0;
      end
    end
    wb_valid = 0;
    checks++;
    if (k !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", k); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (k == 4 && acc_cyc[i] - acc_cyc[i-1] !== 2) begin
        errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 2", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    @(posedge clk); #1;
    start_read(5'd1, 5'd2, 5'd4, 1'b1, 8'h11, 8'h22, "b2b_rd_1_2");
    release_op("b2b_rd_1_2");
    start_read(5'd3, 5'd4, 5'd5, 1'b0, 8'h33, 8'h44, "b2b_rd_3_4");
    release_op("b2b_rd_3_4");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_protect();
    test_priority();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
